// File: rtl/traffic_gen_source.sv
// NoC packet-injection source: periodic bursts of sequence-numbered headers to a tx serialiser.
// Optional statistics ports (sent_count, stall_cycles) are built when TRAFFIC_STATS_EN is defined.
module traffic_gen_source #(
  parameter int          NODE_ID   = 0,
  parameter int          NUM_NODES = 16,
  parameter int          DEST_W    = 4,
  parameter int          SEQ_W     = 8,
  parameter int          SIZE      = 16,
  parameter int          PIR_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DEST_W-1:0] fixed_dest,
  input  logic [PIR_W-1:0]  pir,
  input  logic [3:0]        burst_len,
  input  logic [CNT_W-1:0]  pkt_limit,
  input  logic              busy,
  output logic              req,
  output logic [SIZE-1:0]   data,
  output logic              done
`ifdef TRAFFIC_STATS_EN
  ,
  output logic [CNT_W-1:0]  sent_count,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FIXED      = 2'd0,
    MODE_NEIGHBOUR  = 2'd1,
    MODE_COMPLEMENT = 2'd2,
    MODE_RANDOM     = 2'd3
  } mode_e;

  // Node-count comparisons are done one bit wider so NUM_NODES == 2**DEST_W is representable.
  localparam logic [DEST_W:0]   NN_EXT     = (DEST_W + 1)'(NUM_NODES);
  localparam logic [DEST_W-1:0] NN_LOW     = NN_EXT[DEST_W-1:0];
  localparam logic [DEST_W-1:0] NODE       = DEST_W'(NODE_ID);
  localparam logic [DEST_W-1:0] LAST_NODE  = DEST_W'(NUM_NODES - 1);
  localparam logic [DEST_W-1:0] NEIGHBOUR  = (NODE_ID + 1 >= NUM_NODES) ? '0 : DEST_W'(NODE_ID + 1);
  localparam logic [DEST_W-1:0] COMP_RAW   = ~NODE;
  localparam logic [DEST_W-1:0] COMPLEMENT = ({1'b0, COMP_RAW} >= NN_EXT) ?
                                             DEST_W'(NUM_NODES - 1 - NODE_ID) : COMP_RAW;
  localparam logic [15:0]       SEED_MIX   = SEED ^ 16'(NODE_ID);
  localparam logic [15:0]       LFSR_INIT  = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;
  localparam logic [15:0]       LFSR_TAPS  = 16'hB400;

  state_e            r_state;
  logic [PIR_W-1:0]  r_gap;
  logic [3:0]        r_burst;
  logic [SEQ_W-1:0]  r_seq;
  logic [CNT_W-1:0]  r_sent;
  logic [15:0]       r_lfsr;
  logic              r_req;
  logic [SIZE-1:0]   r_data;
  logic              r_done;

  mode_e             w_mode;
  logic [DEST_W-1:0] w_fixed;
  logic [DEST_W-1:0] w_rnd_raw;
  logic [DEST_W-1:0] w_rnd_fold;
  logic [DEST_W-1:0] w_rnd;
  logic [DEST_W-1:0] w_dest;
  logic [SIZE-1:0]   w_header;
  logic [3:0]        w_burst_eff;
  logic [15:0]       w_lfsr_next;
  logic              w_limit_hit;

  assign w_mode      = mode_e'(mode);
  assign w_fixed     = ({1'b0, fixed_dest} >= NN_EXT) ? LAST_NODE : fixed_dest;
  assign w_rnd_raw   = r_lfsr[DEST_W-1:0];
  assign w_rnd_fold  = ({1'b0, w_rnd_raw} >= NN_EXT) ? (w_rnd_raw - NN_LOW) : w_rnd_raw;
  assign w_rnd       = (w_rnd_fold == NODE) ? NEIGHBOUR : w_rnd_fold;
  assign w_burst_eff = (burst_len == 4'd0) ? 4'd1 : burst_len;
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign w_limit_hit = (pkt_limit != '0) && (r_sent == pkt_limit);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    w_dest = w_fixed;
    case (w_mode)
      MODE_FIXED:      w_dest = w_fixed;
      MODE_NEIGHBOUR:  w_dest = NEIGHBOUR;
      MODE_COMPLEMENT: w_dest = COMPLEMENT;
      MODE_RANDOM:     w_dest = w_rnd;
      default:         w_dest = w_fixed;
    endcase
  end

  always_comb begin
    w_header                                 = '0;
    w_header[DEST_W-1:0]                     = w_dest;
    w_header[2*DEST_W-1:DEST_W]              = NODE;
    w_header[2*DEST_W+SEQ_W-1:2*DEST_W]      = r_seq;
  end

  // The post-issue decision is taken in the req cycle, so sent/burst already hold their new values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_burst <= '0;
      r_seq   <= '0;
      r_sent  <= '0;
      r_lfsr  <= LFSR_INIT;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes req a single-cycle pulse unless an issue overrides it below.
      r_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_GAP;
            r_gap   <= '0;
          end
        end
        ST_GAP: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (r_gap >= pir) begin
            r_state <= ST_ISSUE;
            r_burst <= '0;
          end else begin
            r_gap <= r_gap + PIR_W'(1);
          end
        end
        ST_ISSUE: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (r_req) begin
            if (w_limit_hit) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (r_burst >= w_burst_eff) begin
              r_state <= ST_GAP;
              r_gap   <= '0;
            end
          end else if (!busy) begin
            r_req   <= 1'b1;
            r_data  <= w_header;
            r_seq   <= r_seq + SEQ_W'(1);
            r_sent  <= r_sent + CNT_W'(1);
            r_burst <= r_burst + 4'd1;
            r_lfsr  <= w_lfsr_next;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req  = r_req;
  assign data = r_data;
  assign done = r_done;

`ifdef TRAFFIC_STATS_EN
  logic [CNT_W-1:0] r_stall;

  // A stall is an ISSUE cycle that could have issued but for busy; saturates rather than wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if ((r_state == ST_ISSUE) && busy && !r_req && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign sent_count   = r_sent;
  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_traffic_gen_source.sv
// Bench for traffic_gen_source: two nodes (3 and 11 of 12) share stimulus; a packet-level model
// predicts headers from the destination rules and req timing from gap/burst arithmetic.
module tb_traffic_gen_source;

  localparam int NN   = 12;
  localparam int ID_A = 3;
  localparam int ID_B = 11;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        enable     = 1'b0;
  logic [1:0]  mode       = 2'd0;
  logic [3:0]  fixed_dest = 4'd0;
  logic [7:0]  pir        = 8'd0;
  logic [3:0]  burst_len  = 4'd1;
  logic [15:0] pkt_limit  = 16'd0;
  logic        busy       = 1'b0;

  logic        req_a, req_b, done_a, done_b;
  logic [15:0] data_a, data_b;
`ifdef TRAFFIC_STATS_EN
  logic [15:0] sent_a, stall_a, sent_b, stall_b;
`endif

  traffic_gen_source #(.NODE_ID(ID_A), .NUM_NODES(NN), .DEST_W(4), .SEQ_W(8), .SIZE(16),
                       .PIR_W(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .fixed_dest(fixed_dest),
    .pir(pir), .burst_len(burst_len), .pkt_limit(pkt_limit), .busy(busy),
    .req(req_a), .data(data_a), .done(done_a)
`ifdef TRAFFIC_STATS_EN
    , .sent_count(sent_a), .stall_cycles(stall_a)
`endif
  );

  traffic_gen_source #(.NODE_ID(ID_B), .NUM_NODES(NN), .DEST_W(4), .SEQ_W(8), .SIZE(16),
                       .PIR_W(8), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .fixed_dest(fixed_dest),
    .pir(pir), .burst_len(burst_len), .pkt_limit(pkt_limit), .busy(busy),
    .req(req_b), .data(data_b), .done(done_b)
`ifdef TRAFFIC_STATS_EN
    , .sent_count(sent_b), .stall_cycles(stall_b)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    int          cyc;
    logic        ra;
    logic        rb;
    logic [15:0] a;
    logic [15:0] b;
  } pkt_t;

  pkt_t q[$];
  pkt_t mon_rec;

  always @(negedge clk) begin
    if (req_a === 1'b1 || req_b === 1'b1) begin
      mon_rec.cyc = cyc;
      mon_rec.ra  = req_a;
      mon_rec.rb  = req_b;
      mon_rec.a   = data_a;
      mon_rec.b   = data_b;
      q.push_back(mon_rec);
    end
  end

  int checks = 0;
  int errors = 0;

  // Packet-level reference model.
  logic [7:0]  m_seq;
  logic [15:0] m_lf_a, m_lf_b;

  function automatic logic [15:0] seed_of(int id);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(id);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int m_dest(int node, int md, int fx, logic [15:0] lf);
    int nb, r;
    nb = (node + 1) % NN;
    case (md)
      0:       r = (fx >= NN) ? NN - 1 : fx;
      1:       r = nb;
      2:       begin r = (~node) & 15; if (r >= NN) r = NN - 1 - node; end
      default: begin
        r = int'(lf[3:0]);
        if (r >= NN) r = r - NN;
        if (r == node) r = nb;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] hdr(int dest, int node, logic [7:0] seq);
    return {seq, 4'(node), 4'(dest)};
  endfunction

  task automatic model_reset;
    m_seq  = 8'd0;
    m_lf_a = seed_of(ID_A);
    m_lf_b = seed_of(ID_B);
  endtask

  task automatic next_exp(input int md, input int fx, output logic [15:0] ha, output logic [15:0] hb);
    ha     = hdr(m_dest(ID_A, md, fx, m_lf_a), ID_A, m_seq);
    hb     = hdr(m_dest(ID_B, md, fx, m_lf_b), ID_B, m_seq);
    m_seq  = m_seq + 8'd1;
    m_lf_a = lfsr_step(m_lf_a);
    m_lf_b = lfsr_step(m_lf_b);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pkt(output pkt_t p, output bit ok);
    ok = 1'b0;
    p  = '0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() > 0) begin
        p  = q.pop_front();
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic restart(input int md, input int fx, input int p, input int bl, input int lim,
                         output int t_en);
    enable = 1'b0;
    repeat (3) tick();
    mode       = 2'(md);
    fixed_dest = 4'(fx);
    pir        = 8'(p);
    burst_len  = 4'(bl);
    pkt_limit  = 16'(lim);
    enable     = 1'b1;
    t_en       = cyc;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick();
    checks += 3;
    if ({req_a, req_b} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b want 00", {req_a, req_b}); end
    if (data_a !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", data_a); end
    if ({done_a, done_b} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {done_a, done_b}); end
`ifdef TRAFFIC_STATS_EN
    checks++;
    if ({sent_a, stall_a} !== 32'h0) begin errors++; $display("FAIL reset_stats: got %h want 0", {sent_a, stall_a}); end
`endif
    reset = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_periodic;
    pkt_t p; bit ok; logic [15:0] ha, hb; int exp_cyc;
    mode = 2'd0; fixed_dest = 4'd5; pir = 8'd3; burst_len = 4'd1; pkt_limit = 16'd0; busy = 1'b0;
    enable  = 1'b1;
    exp_cyc = cyc;
    ha = 16'h0;
    for (int k = 0; k < 5; k++) begin
      wait_pkt(p, ok);
      next_exp(0, 5, ha, hb);
      exp_cyc = exp_cyc + 6;
      checks++;
      if (!ok) begin errors++; $display("FAIL periodic_timeout: pkt %0d not seen", k); end
      else begin
        checks += 3;
        if (p.cyc != exp_cyc) begin errors++; $display("FAIL periodic_cycle: pkt %0d at %0d want %0d", k, p.cyc, exp_cyc); end
        if ({p.ra, p.a} !== {1'b1, ha}) begin errors++; $display("FAIL periodic_hdr_a: got %h want %h", p.a, ha); end
        if ({p.rb, p.b} !== {1'b1, hb}) begin errors++; $display("FAIL periodic_hdr_b: got %h want %h", p.b, hb); end
      end
    end
    tick();
    tick();
    checks++;
    if ({req_a, data_a} !== {1'b0, ha}) begin errors++; $display("FAIL data_hold: got req=%b data=%h want req=0 data=%h", req_a, data_a, ha); end
  endtask

  task automatic test_dest_modes;
    pkt_t p; bit ok; logic [15:0] ha, hb; int t_en;
    int md_tab[5] = '{0, 0, 1, 2, 0};
    int fx_tab[5] = '{15, 7, 0, 0, 5};
    restart(md_tab[0], fx_tab[0], 3, 1, 0, t_en);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        mode       = 2'(md_tab[k]);
        fixed_dest = 4'(fx_tab[k]);
      end
      wait_pkt(p, ok);
      next_exp(md_tab[k], fx_tab[k], ha, hb);
      checks++;
      if (!ok) begin errors++; $display("FAIL dest_timeout: entry %0d", k); end
      else begin
        checks += 2;
        if (p.a !== ha) begin errors++; $display("FAIL dest_a mode %0d: got %h want %h", md_tab[k], p.a, ha); end
        if ({p.rb, p.b} !== {1'b1, hb}) begin errors++; $display("FAIL dest_b mode %0d: got %h want %h", md_tab[k], p.b, hb); end
      end
    end
  endtask

  task automatic test_burst;
    pkt_t p; bit ok; logic [15:0] ha, hb; int exp_cyc;
    restart(0, 9, 10, 3, 0, exp_cyc);
    for (int k = 0; k < 6; k++) begin
      wait_pkt(p, ok);
      next_exp(0, 9, ha, hb);
      exp_cyc = exp_cyc + ((k % 3 == 0) ? 13 : 2);
      checks++;
      if (!ok) begin errors++; $display("FAIL burst_timeout: pkt %0d", k); end
      else begin
        checks += 2;
        if (p.cyc != exp_cyc) begin errors++; $display("FAIL burst_cycle: pkt %0d at %0d want %0d", k, p.cyc, exp_cyc); end
        if ({p.ra, p.a} !== {1'b1, ha}) begin errors++; $display("FAIL burst_hdr: got %h want %h", p.a, ha); end
      end
    end
  endtask

  task automatic test_busy_stall;
    pkt_t p; bit ok; logic [15:0] ha, hb; int exp_cyc, s;
`ifdef TRAFFIC_STATS_EN
    logic [15:0] stall0;
`endif
    restart(0, 1, 10, 3, 0, exp_cyc);
    wait_pkt(p, ok);
    next_exp(0, 1, ha, hb);
    checks++;
    if (!ok || p.cyc != exp_cyc + 13 || p.a !== ha) begin
      errors++; $display("FAIL stall_first: ok=%b at %0d want %0d, hdr %h want %h", ok, p.cyc, exp_cyc + 13, p.a, ha);
    end
    tick();
    s = cyc;
`ifdef TRAFFIC_STATS_EN
    stall0 = stall_a;
`endif
    busy = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    busy = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL stall_no_req: got %0d reqs want 0", q.size()); end
`ifdef TRAFFIC_STATS_EN
    checks++;
    if (stall_a !== stall0 + 16'd20) begin errors++; $display("FAIL stall_count: got %0d want %0d", stall_a, stall0 + 16'd20); end
`endif
    exp_cyc = s + 21;
    for (int k = 0; k < 3; k++) begin
      wait_pkt(p, ok);
      next_exp(0, 1, ha, hb);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_timeout: pkt %0d", k); end
      else begin
        checks += 2;
        if (p.cyc != exp_cyc) begin errors++; $display("FAIL stall_resume_cycle: pkt %0d at %0d want %0d", k, p.cyc, exp_cyc); end
        if (p.a !== ha) begin errors++; $display("FAIL stall_hdr: got %h want %h", p.a, ha); end
      end
      exp_cyc = exp_cyc + ((k == 0) ? 2 : 13);
    end
  endtask

  task automatic test_disable_restart;
    pkt_t p; bit ok; logic [15:0] ha, hb; int exp_cyc;
    restart(0, 2, 5, 4, 0, exp_cyc);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        enable = 1'b0;
        repeat (15) tick();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL disabled_req: got %0d reqs want 0", q.size()); end
        enable  = 1'b1;
        exp_cyc = cyc;
      end
      wait_pkt(p, ok);
      next_exp(0, 2, ha, hb);
      exp_cyc = exp_cyc + ((k % 2 == 0) ? 8 : 2);
      checks++;
      if (!ok) begin errors++; $display("FAIL restart_timeout: pkt %0d", k); end
      else begin
        checks += 2;
        if (p.cyc != exp_cyc) begin errors++; $display("FAIL restart_cycle: pkt %0d at %0d want %0d", k, p.cyc, exp_cyc); end
        if (p.a !== ha) begin errors++; $display("FAIL restart_seq: got %h want %h", p.a, ha); end
      end
    end
  endtask

  task automatic test_random;
    pkt_t p; bit ok; logic [15:0] ha, hb; int da, db, t_en;
    for (int run = 0; run < 2; run++) begin
      enable = 1'b0;
      reset  = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      restart(3, 0, 0, 15, 0, t_en);
      for (int k = 0; k < 200; k++) begin
        if (k % 37 == 5) begin
          busy = 1'b1;
          repeat ($urandom_range(1, 4)) tick();
          busy = 1'b0;
        end
        wait_pkt(p, ok);
        next_exp(3, 0, ha, hb);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_timeout: run %0d pkt %0d", run, k); end
        else begin
          da = int'(p.a[3:0]);
          db = int'(p.b[3:0]);
          checks += 3;
          if (da >= NN || da == ID_A || db >= NN || db == ID_B) begin
            errors++; $display("FAIL random_range: run %0d pkt %0d dest_a %0d dest_b %0d", run, k, da, db);
          end
          if (p.a !== ha) begin errors++; $display("FAIL random_hdr_a: run %0d pkt %0d got %h want %h", run, k, p.a, ha); end
          if ({p.rb, p.b} !== {1'b1, hb}) begin errors++; $display("FAIL random_hdr_b: run %0d pkt %0d got %h want %h", run, k, p.b, hb); end
        end
      end
    end
  endtask

  task automatic test_limit;
    pkt_t p; bit ok; logic [15:0] ha, hb; int exp_cyc;
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    restart(0, 6, 2, 2, 4, exp_cyc);
    for (int k = 0; k < 4; k++) begin
      wait_pkt(p, ok);
      next_exp(0, 6, ha, hb);
      exp_cyc = exp_cyc + ((k % 2 == 0) ? 5 : 2);
      checks++;
      if (!ok) begin errors++; $display("FAIL limit_timeout: pkt %0d", k); end
      else begin
        checks += 2;
        if (p.cyc != exp_cyc) begin errors++; $display("FAIL limit_cycle: pkt %0d at %0d want %0d", k, p.cyc, exp_cyc); end
        if (p.a !== ha) begin errors++; $display("FAIL limit_hdr: got %h want %h", p.a, ha); end
      end
    end
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL done_early: got %b want 0", done_a); end
    tick();
    checks++;
    if ({done_a, done_b} !== 2'b11) begin errors++; $display("FAIL done_set: got %b want 11", {done_a, done_b}); end
`ifdef TRAFFIC_STATS_EN
    checks++;
    if (sent_a !== 16'd4) begin errors++; $display("FAIL sent_count: got %0d want 4", sent_a); end
`endif
    for (int i = 0; i < 6; i++) begin
      enable = ~enable;
      repeat (5) tick();
    end
    checks += 2;
    if (q.size() != 0) begin errors++; $display("FAIL done_extra_req: got %0d reqs want 0", q.size()); end
    if (done_a !== 1'b1) begin errors++; $display("FAIL done_hold: got %b want 1", done_a); end
    reset = 1'b0;
    #1;
    checks++;
    if ({done_a, req_a} !== 2'b00) begin errors++; $display("FAIL done_clear: got %b want 00", {done_a, req_a}); end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_dest_modes();
    test_burst();
    test_busy_stall();
    test_disable_restart();
    test_random();
    test_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
